// File: rtl/ppu_row_scanout_if.sv
// Bus between the row scan-out block and its RAMs, the PPU and the HDMI transmitter.
// The master side is the scan-out block; the slave side owns the RAM read data.
interface ppu_row_scanout_if;
  logic [8:0]  hdmi_rowram_rdaddr;
  logic [8:0]  hdmi_rowram_rddata;
  logic [8:0]  hdmi_palram_rdaddr;
  logic [23:0] hdmi_palram_rddata;
  logic        rowram_swap;
  logic [7:0]  next_row;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;

  modport master (
    output hdmi_rowram_rdaddr,
    input  hdmi_rowram_rddata,
    output hdmi_palram_rdaddr,
    input  hdmi_palram_rddata,
    output rowram_swap,
    output next_row,
    output hsync,
    output vsync,
    output de,
    output rgb
  );

  modport slave (
    input  hdmi_rowram_rdaddr,
    output hdmi_rowram_rddata,
    input  hdmi_palram_rdaddr,
    output hdmi_palram_rddata,
    input  rowram_swap,
    input  next_row,
    input  hsync,
    input  vsync,
    input  de,
    input  rgb
  );
endinterface

// File: rtl/ppu_row_scanout.sv
// Display-side consumer of the PPU row double-buffer: raster timing, row/palette lookup
// with 2x pixel doubling, and the row-buffer swap schedule that paces ppu_logic.
module ppu_row_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic               clk,
  input logic               rst,
  ppu_row_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int ROWS    = V_ACTIVE / 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Last line carrying a mid-frame swap: v = 2*(ROWS-1)-1.
  localparam logic [VW-1:0] V_LAST_SWAP = VW'(2 * ROWS - 3);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  logic          active_s;
  logic          hs_s;
  logic          vs_s;
  logic          sched_s;
  logic [7:0]    sched_row_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic          swap_nx_s;
  logic [7:0]    row_nx_s;
  logic          swap_r;
  logic [7:0]    next_row_r;

  logic [8:0]    rowram_rdaddr_r;
  logic [8:0]    palram_rdaddr_r;
  logic [4:0]    act_sr;
  logic [4:0]    hs_sr;
  logic [4:0]    vs_sr;
  logic [23:0]   rgb_r;

  // Raster counters; reset parks the raster at the top of vblank.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r <= '0;
      v_r <= V_ACT;
    end else if (h_r == H_LAST) begin
      h_r <= '0;
      if (v_r == V_LAST) begin
        v_r <= '0;
      end else begin
        v_r <= v_r + VW'(1);
      end
    end else begin
      h_r <= h_r + HW'(1);
    end
  end

  // Raw timing and swap schedule decoded from the current counter position.
  always_comb begin
    active_s = (h_r < H_ACT) && (v_r < V_ACT);
    hs_s     = !((h_r >= HS_START) && (h_r < HS_END));
    vs_s     = !((v_r >= VS_START) && (v_r < VS_END));
    sched_s  = (h_r == H_ACT) && ((v_r[0] && (v_r <= V_LAST_SWAP)) || (v_r == V_LAST));
    if (v_r == V_LAST) begin
      sched_row_s = 8'd1;
    end else if (v_r == V_LAST_SWAP) begin
      sched_row_s = 8'd0;
    end else begin
      sched_row_s = 8'((v_r + VW'(3)) >> 1);
    end
  end

  // Swap controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_PRIME;
      swap_r     <= 1'b0;
      next_row_r <= 8'd0;
    end else begin
      state_r    <= state_nx_s;
      swap_r     <= swap_nx_s;
      next_row_r <= row_nx_s;
    end
  end

  // Priming request for row 0 wins over any scheduled pulse in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    swap_nx_s  = 1'b0;
    row_nx_s   = next_row_r;
    case (state_r)
      ST_PRIME: begin
        state_nx_s = ST_RUN;
        swap_nx_s  = 1'b1;
        row_nx_s   = 8'd0;
      end
      ST_RUN: begin
        if (sched_s) begin
          swap_nx_s = 1'b1;
          row_nx_s  = sched_row_s;
        end else begin
          swap_nx_s = 1'b0;
          row_nx_s  = next_row_r;
        end
      end
      default: begin
        state_nx_s = ST_PRIME;
        swap_nx_s  = 1'b0;
        row_nx_s   = 8'd0;
      end
    endcase
  end

  // Five-stage pixel pipeline: row RAM, palette RAM, then the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowram_rdaddr_r <= 9'd0;
      palram_rdaddr_r <= 9'd0;
      act_sr          <= 5'b00000;
      hs_sr           <= 5'b11111;
      vs_sr           <= 5'b11111;
      rgb_r           <= 24'd0;
    end else begin
      rowram_rdaddr_r <= active_s ? 9'(h_r >> 1) : 9'd0;
      palram_rdaddr_r <= bus.hdmi_rowram_rddata;
      act_sr          <= {act_sr[3:0], active_s};
      hs_sr           <= {hs_sr[3:0], hs_s};
      vs_sr           <= {vs_sr[3:0], vs_s};
      rgb_r           <= act_sr[3] ? bus.hdmi_palram_rddata : 24'd0;
    end
  end

  assign bus.hdmi_rowram_rdaddr = rowram_rdaddr_r;
  assign bus.hdmi_palram_rdaddr = palram_rdaddr_r;
  assign bus.rowram_swap        = swap_r;
  assign bus.next_row           = next_row_r;
  assign bus.de                 = act_sr[4];
  assign bus.hsync              = hs_sr[4];
  assign bus.vsync              = vs_sr[4];
  assign bus.rgb                = rgb_r;

endmodule

// File: tb/tb_ppu_row_scanout.sv
// Bench for ppu_row_scanout: a full-width/short-frame instance (a) and a narrow/full-height
// instance (b), both checked cycle by cycle against a queue-based timing/swap model.
module tb_ppu_row_scanout;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vid_t;

  typedef struct {int x; int rgb;} pix_rec_t;
  typedef struct {int v; int nr;}  row_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppu_row_scanout_if ifa ();
  ppu_row_scanout_if ifb ();

  ppu_row_scanout #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  ppu_row_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Row RAM returns its address, palette returns {15'b0, index}; both 1-cycle latency.
  always @(posedge clk) begin
    ifa.hdmi_rowram_rddata <= ifa.hdmi_rowram_rdaddr;
    ifa.hdmi_palram_rddata <= {15'b0, ifa.hdmi_palram_rdaddr};
    ifb.hdmi_rowram_rddata <= ifb.hdmi_rowram_rdaddr;
    ifb.hdmi_palram_rddata <= {15'b0, ifb.hdmi_palram_rdaddr};
  end

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int rel_cnt = 0;

  int HA[2], HFP[2], HSW[2], HT[2], VA[2], VFP[2], VSW[2], VT[2];

  int   mh[2], mv[2];
  bit   mprime[2];
  logic exp_sw[2];
  int   exp_nr[2];
  vid_t exp_v[2];
  bit   pv_prime[2];
  int   pv_h[2], pv_v[2];
  vid_t qa[$];
  vid_t qb[$];

  int   hs_fall[2], vs_fall[2], last_de_fall[2], de_run[2], de_lines[2], pulses[2], first_de[2];
  logic p_hs[2], p_vs[2], p_de[2];
  int   pix[0:639];
  int   line_nr[0:524];

  pix_rec_t ptab[7];
  row_rec_t rtab[6];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cnt, got, exp);
    end
  endtask

  function automatic vid_t raw_out(int i, int h, int v);
    vid_t r;
    r.de  = (h < HA[i]) && (v < VA[i]);
    r.hs  = !((h >= HA[i] + HFP[i]) && (h < HA[i] + HFP[i] + HSW[i]));
    r.vs  = !((v >= VA[i] + VFP[i]) && (v < VA[i] + VFP[i] + VSW[i]));
    r.rgb = r.de ? 24'(h / 2) : 24'd0;
    return r;
  endfunction

  task automatic model_edge(int i);
    vid_t idle;
    vid_t nv;
    bit   sched;
    idle = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'd0};
    if (rst) begin
      mh[i] = 0;
      mv[i] = VA[i];
      mprime[i] = 1'b1;
      exp_sw[i] = 1'b0;
      exp_nr[i] = 0;
      exp_v[i] = idle;
      pv_prime[i] = 1'b0;
      if (i == 0) begin
        qa.delete();
        repeat (4) qa.push_back(idle);
      end else begin
        qb.delete();
        repeat (4) qb.push_back(idle);
      end
    end else begin
      sched = (mh[i] == HA[i]) && ((mv[i] == VT[i] - 1) || ((mv[i] % 2 == 1) && (mv[i] < VA[i] - 2)));
      pv_prime[i] = mprime[i];
      pv_h[i] = mh[i];
      pv_v[i] = mv[i];
      exp_sw[i] = mprime[i] || sched;
      if (mprime[i]) exp_nr[i] = 0;
      else if (sched) exp_nr[i] = (mv[i] == VT[i] - 1) ? 1 : (((mv[i] + 1) / 2) + 1) % (VA[i] / 2);
      mprime[i] = 1'b0;
      nv = raw_out(i, mh[i], mv[i]);
      if (i == 0) begin
        qa.push_back(nv);
        exp_v[i] = qa.pop_front();
      end else begin
        qb.push_back(nv);
        exp_v[i] = qb.pop_front();
      end
      mh[i]++;
      if (mh[i] == HT[i]) begin
        mh[i] = 0;
        mv[i] = (mv[i] + 1) % VT[i];
      end
    end
  endtask

  task automatic measure(int i, logic de, logic hs, logic vs, logic sw, logic [7:0] nr, logic [23:0] rgb);
    if (rst) begin
      hs_fall[i] = -1; vs_fall[i] = -1; last_de_fall[i] = -1;
      de_run[i] = 0; de_lines[i] = 0; pulses[i] = 0;
      p_hs[i] = 1'b1; p_vs[i] = 1'b1; p_de[i] = 1'b0;
      return;
    end
    if (p_hs[i] && !hs) begin
      if (hs_fall[i] >= 0) chk($sformatf("hs_period_%0d", i), cnt - hs_fall[i], HT[i]);
      hs_fall[i] = cnt;
    end
    if (!p_hs[i] && hs && hs_fall[i] >= 0) chk($sformatf("hs_low_%0d", i), cnt - hs_fall[i], HSW[i]);
    if (de) begin
      if (!p_de[i]) begin
        de_run[i] = 0;
        de_lines[i]++;
        if (first_de[i] < 0) first_de[i] = cnt - rel_cnt;
      end
      if (i == 0 && de_run[i] < 640) pix[de_run[i]] = int'(rgb);
      de_run[i]++;
    end else if (p_de[i]) begin
      chk($sformatf("de_run_%0d", i), de_run[i], HA[i]);
      last_de_fall[i] = cnt;
    end
    if (p_vs[i] && !vs) begin
      if (vs_fall[i] >= 0) begin
        chk($sformatf("de_lines_%0d", i), de_lines[i], VA[i]);
        chk($sformatf("pulses_%0d", i), pulses[i], VA[i] / 2);
      end
      if (last_de_fall[i] >= 0)
        chk($sformatf("vs_after_de_%0d", i), cnt - last_de_fall[i], VFP[i] * HT[i] + HT[i] - HA[i]);
      vs_fall[i] = cnt;
      de_lines[i] = 0;
      pulses[i] = 0;
    end
    if (!p_vs[i] && vs && vs_fall[i] >= 0) chk($sformatf("vs_low_%0d", i), cnt - vs_fall[i], VSW[i] * HT[i]);
    if (sw) begin
      pulses[i]++;
      if (!pv_prime[i]) begin
        chk($sformatf("swap_h_%0d", i), pv_h[i], HA[i]);
        if (i == 1) line_nr[pv_v[1]] = int'(nr);
      end
    end
    p_hs[i] = hs;
    p_vs[i] = vs;
    p_de[i] = de;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cnt++;
    @(negedge clk);
    chk("cyc_a", {ifa.de, ifa.hsync, ifa.vsync, ifa.rgb, ifa.rowram_swap, ifa.next_row},
                 {exp_v[0], exp_sw[0], 8'(exp_nr[0])});
    chk("cyc_b", {ifb.de, ifb.hsync, ifb.vsync, ifb.rgb, ifb.rowram_swap, ifb.next_row},
                 {exp_v[1], exp_sw[1], 8'(exp_nr[1])});
    measure(0, ifa.de, ifa.hsync, ifa.vsync, ifa.rowram_swap, ifa.next_row, ifa.rgb);
    measure(1, ifb.de, ifb.hsync, ifb.vsync, ifb.rowram_swap, ifb.next_row, ifb.rgb);
  endtask

  task automatic chk_rst(string tag, logic de, logic hs, logic vs, logic sw, logic [23:0] rgb,
                         logic [7:0] nr, logic [8:0] ra, logic [8:0] pa);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_hsync"}, hs, 1'b1);
    chk({tag, "_vsync"}, vs, 1'b1);
    chk({tag, "_swap"}, sw, 1'b0);
    chk({tag, "_rgb"}, rgb, 24'd0);
    chk({tag, "_next_row"}, nr, 8'd0);
    chk({tag, "_rowram_rdaddr"}, ra, 9'd0);
    chk({tag, "_palram_rdaddr"}, pa, 9'd0);
  endtask

  task automatic release_and_check_prime();
    rst = 1'b0;
    rel_cnt = cnt;
    first_de[0] = -1;
    first_de[1] = -1;
    cyc();
    chk("prime_swap_a", ifa.rowram_swap, 1'b1);
    chk("prime_row_a", ifa.next_row, 8'd0);
    chk("prime_swap_b", ifb.rowram_swap, 1'b1);
    chk("prime_row_b", ifb.next_row, 8'd0);
  endtask

  initial begin
    HA[0] = 640; HFP[0] = 16; HSW[0] = 96; HT[0] = 800;
    VA[0] = 6;   VFP[0] = 1;  VSW[0] = 2;  VT[0] = 11;
    HA[1] = 16;  HFP[1] = 2;  HSW[1] = 4;  HT[1] = 24;
    VA[1] = 480; VFP[1] = 10; VSW[1] = 2;  VT[1] = 525;
    for (int k = 0; k < 640; k++) pix[k] = -1;
    for (int k = 0; k < 525; k++) line_nr[k] = -1;
    ptab[0] = '{0, 0};   ptab[1] = '{1, 0};     ptab[2] = '{2, 1};   ptab[3] = '{3, 1};
    ptab[4] = '{101, 50}; ptab[5] = '{638, 319}; ptab[6] = '{639, 319};
    rtab[0] = '{1, 2};   rtab[1] = '{3, 3};     rtab[2] = '{5, 4};
    rtab[3] = '{239, 121}; rtab[4] = '{477, 0}; rtab[5] = '{524, 1};

    rst = 1'b1;
    repeat (3) cyc();
    chk_rst("rst_a", ifa.de, ifa.hsync, ifa.vsync, ifa.rowram_swap, ifa.rgb, ifa.next_row,
            ifa.hdmi_rowram_rdaddr, ifa.hdmi_palram_rdaddr);
    chk_rst("rst_b", ifb.de, ifb.hsync, ifb.vsync, ifb.rowram_swap, ifb.rgb, ifb.next_row,
            ifb.hdmi_rowram_rdaddr, ifb.hdmi_palram_rdaddr);
    release_and_check_prime();

    repeat (13000) cyc();
    chk("first_de_a", first_de[0], (VT[0] - VA[0]) * HT[0] + 5);
    chk("first_de_b", first_de[1], (VT[1] - VA[1]) * HT[1] + 5);
    for (int k = 0; k < 7; k++) chk($sformatf("pix_%0d", ptab[k].x), pix[ptab[k].x], ptab[k].rgb);
    for (int k = 0; k < 6; k++) chk($sformatf("row_at_v%0d", rtab[k].v), line_nr[rtab[k].v], rtab[k].nr);

    // Mid-frame reset while instance b sits at v=200.
    for (int k = 0; k < 20000 && !(mv[1] == 200 && mh[1] == 10); k++) cyc();
    chk("reach_v200", (mv[1] == 200 && mh[1] == 10), 1'b1);
    rst = 1'b1;
    cyc();
    chk_rst("mid_rst_a", ifa.de, ifa.hsync, ifa.vsync, ifa.rowram_swap, ifa.rgb, ifa.next_row,
            ifa.hdmi_rowram_rdaddr, ifa.hdmi_palram_rdaddr);
    chk_rst("mid_rst_b", ifb.de, ifb.hsync, ifb.vsync, ifb.rowram_swap, ifb.rgb, ifb.next_row,
            ifb.hdmi_rowram_rdaddr, ifb.hdmi_palram_rdaddr);
    cyc();
    release_and_check_prime();
    repeat (9000) cyc();
    chk("mid_first_de_a", first_de[0], (VT[0] - VA[0]) * HT[0] + 5);
    chk("mid_first_de_b", first_de[1], (VT[1] - VA[1]) * HT[1] + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
